// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus between pc_fetch_unit (master) and instruction memory (slave).
// The bus carries one request and at most one outstanding response.

interface pc_fetch_unit_if;
  // Handshake: a request transfers on any cycle with imem_req && imem_gnt. While imem_req is
  // high and gnt is low, the master holds imem_addr constant. The response is a single-cycle
  // imem_rvalid pulse that carries imem_rdata. The response path has no backpressure.
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Architectural PC register and single-outstanding instruction fetch for the sequential core.
// Optional macro PC_MISALIGN_TRAP_EN adds the misalign output and a terminal TRAP state.

module pc_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [63:0]           next_pc,
  input  logic                  pc_update,
  pc_fetch_unit_if.master       mem,
  output logic [63:0]           pc_out,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  output logic                  fetch_err,
`ifdef PC_MISALIGN_TRAP_EN
  output logic                  misalign,
`endif
  output logic [1:0]            fsm_state
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [1:0] TRAP  = 2'd3;
`endif

  localparam logic [31:0] NOP      = 32'h0000_0013;
  // The counter value seen in the last WAIT cycle before a timeout is declared.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [15:0] cnt;

  // Gating with reset keeps the request low while reset is held, even though state is FETCH.
  assign mem.imem_req  = (state == FETCH) && !reset;
  assign mem.imem_addr = pc_out;
  assign fsm_state     = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      cnt         <= 16'd0;
      pc_out      <= RESET_PC;
      instr       <= NOP;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign    <= 1'b0;
`endif
    end else begin
      fetch_err <= 1'b0;
      case (state)
        // rvalid is deliberately ignored here, so stale responses are dropped.
        FETCH: begin
          if (mem.imem_gnt) begin
            state <= WAIT;
            cnt   <= 16'd0;
          end
        end
        WAIT: begin
          if (mem.imem_rvalid) begin
            instr       <= mem.imem_rdata;
            instr_valid <= 1'b1;
            cnt         <= 16'd0;
            state       <= HOLD;
          end else if (cnt == CNT_LAST) begin
            fetch_err <= 1'b1;
            cnt       <= 16'd0;
            state     <= FETCH;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        HOLD: begin
          if (pc_update) begin
            pc_out      <= next_pc;
            instr_valid <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            if (next_pc[1:0] != 2'b00) begin
              misalign <= 1'b1;
              state    <= TRAP;
            end else begin
              state <= FETCH;
            end
`else
            state <= FETCH;
`endif
          end
        end
`ifdef PC_MISALIGN_TRAP_EN
        TRAP: state <= TRAP;
`endif
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit using RESET_PC=64'h1000 and TIMEOUT=4.
// Inputs change on the falling edge, and outputs are checked on the falling edge.

module tb_pc_fetch_unit;
  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] next_pc;
  logic        pc_update;
  logic [63:0] pc_out;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_err;
  logic [1:0]  fsm_state;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  pc_fetch_unit_if bus();

  pc_fetch_unit #(.RESET_PC(64'h1000), .TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .next_pc    (next_pc),
    .pc_update  (pc_update),
    .mem        (bus.master),
    .pc_out     (pc_out),
    .instr      (instr),
    .instr_valid(instr_valid),
    .fetch_err  (fetch_err),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign   (misalign),
`endif
    .fsm_state  (fsm_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: this task performs one zero-wait fetch. The caller must be at a falling edge in FETCH.
  task automatic fetch_zero_wait(input logic [63:0] addr, input logic [31:0] word, input string name);
    logic [31:0] exp;
    #1;
    tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== addr) begin
      fails++;
      $display("FAIL %s_req: req=%b addr=%h expected req=1 addr=%h", name, bus.imem_req, bus.imem_addr, addr);
    end
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    tests++;
    if (fsm_state !== S_WAIT || instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      fails++;
      $display("FAIL %s_wait: state=%0d valid=%b req=%b expected state=1 valid=0 req=0", name, fsm_state, instr_valid, bus.imem_req);
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = word;
    exp_q.push_back(word);
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    exp = exp_q.pop_front();
    tests++;
    if (instr_valid !== 1'b1 || instr !== exp || fsm_state !== S_HOLD) begin
      fails++;
      $display("FAIL %s_capture: valid=%b instr=%h state=%0d expected valid=1 instr=%h state=2", name, instr_valid, instr, fsm_state, exp);
    end
  endtask

  // Driver: this task retires the current instruction. The caller must be at a falling edge in HOLD.
  task automatic retire(input logic [63:0] target);
    next_pc   = target;
    pc_update = 1'b1;
    @(negedge clk);
    pc_update = 1'b0;
    next_pc   = 64'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pc_update = 1'b0;
    next_pc = 64'h0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (pc_out !== 64'h1000) begin fails++; $display("FAIL reset_pc: got %h expected 1000", pc_out); end
    tests++;
    if (instr !== 32'h0000_0013 || instr_valid !== 1'b0) begin
      fails++; $display("FAIL reset_instr: instr=%h valid=%b expected 00000013 0", instr, instr_valid);
    end
    tests++;
    if (bus.imem_req !== 1'b0 || fetch_err !== 1'b0 || fsm_state !== S_FETCH) begin
      fails++; $display("FAIL reset_ctrl: req=%b err=%b state=%0d expected 0 0 0", bus.imem_req, fetch_err, fsm_state);
    end
    reset = 1'b0;
  endtask

  task automatic test_first_fetch();
    fetch_zero_wait(64'h1000, 32'h0050_0093, "first");
    tests++;
    if (pc_out !== 64'h1000 || fetch_err !== 1'b0) begin
      fails++; $display("FAIL first_hold: pc=%h err=%b expected 1000 0", pc_out, fetch_err);
    end
  endtask

  task automatic test_sequential();
    retire(64'h1004);
    tests++;
    if (pc_out !== 64'h1004 || instr_valid !== 1'b0 || fsm_state !== S_FETCH) begin
      fails++; $display("FAIL seq_update: pc=%h valid=%b state=%0d expected 1004 0 0", pc_out, instr_valid, fsm_state);
    end
    fetch_zero_wait(64'h1004, 32'h0010_0113, "seq");
  endtask

  task automatic test_branch();
    retire(64'h0FF0);
    tests++;
    if (pc_out !== 64'h0FF0 || instr_valid !== 1'b0) begin
      fails++; $display("FAIL branch_update: pc=%h valid=%b expected 0ff0 0", pc_out, instr_valid);
    end
    fetch_zero_wait(64'h0FF0, 32'h0020_0193, "branch");
  endtask

  task automatic test_gnt_stall();
    int bad = 0;
    retire(64'h0FF4);
    for (int i = 0; i < 5; i++) begin
      // The core tries to retire during FETCH; this update must be ignored.
      if (i == 2) begin next_pc = 64'hDEAD_0000; pc_update = 1'b1; end
      else pc_update = 1'b0;
      #1;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0FF4 || fsm_state !== S_FETCH) bad++;
      @(negedge clk);
    end
    pc_update = 1'b0;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL stall_hold: %0d bad cycles expected 0", bad); end
    tests++;
    if (pc_out !== 64'h0FF4) begin fails++; $display("FAIL stall_ignore_update: pc=%h expected 0ff4", pc_out); end
    fetch_zero_wait(64'h0FF4, 32'h0030_0213, "stall");
  endtask

  task automatic test_timeout();
    int bad = 0;
    retire(64'h1008);
    bus.imem_gnt = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.imem_gnt = 1'b0;
      if (fsm_state !== S_WAIT || fetch_err !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL timeout_wait: %0d bad cycles expected 0", bad); end
    @(negedge clk);
    tests++;
    if (fetch_err !== 1'b1 || fsm_state !== S_FETCH || bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h1008) begin
      fails++;
      $display("FAIL timeout_err: err=%b state=%0d req=%b addr=%h expected 1 0 1 1008", fetch_err, fsm_state, bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    tests++;
    if (fetch_err !== 1'b0 || bus.imem_req !== 1'b1) begin
      fails++; $display("FAIL timeout_pulse: err=%b req=%b expected 0 1", fetch_err, bus.imem_req);
    end
    // The re-issued fetch gets its response in the fourth WAIT cycle, so rvalid wins over the timeout.
    bus.imem_gnt = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.imem_gnt = 1'b0;
      if (k == 4) begin bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0040_0293; exp_q.push_back(32'h0040_0293); end
    end
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    tests++;
    if (fetch_err !== 1'b0 || instr_valid !== 1'b1 || instr !== exp_q.pop_front()) begin
      fails++; $display("FAIL timeout_edge: err=%b valid=%b instr=%h expected 0 1 00400293", fetch_err, instr_valid, instr);
    end
  endtask

  task automatic test_wrap();
    retire(64'hFFFF_FFFF_FFFF_FFFC);
    fetch_zero_wait(64'hFFFF_FFFF_FFFF_FFFC, 32'h0050_0313, "wrap_top");
    retire(64'h0);
    tests++;
    if (pc_out !== 64'h0) begin fails++; $display("FAIL wrap_zero: pc=%h expected 0", pc_out); end
    fetch_zero_wait(64'h0, 32'h0060_0393, "wrap_zero");
  endtask

  task automatic test_reset_in_wait();
    retire(64'h100C);
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    #1;
    tests++;
    if (fsm_state !== S_FETCH || pc_out !== 64'h1000 || bus.imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_wait_state: state=%0d pc=%h req=%b valid=%b expected 0 1000 1 0", fsm_state, pc_out, bus.imem_req, instr_valid);
    end
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;
    tests++;
    if (instr_valid !== 1'b0 || instr === 32'hDEAD_BEEF || fsm_state !== S_FETCH) begin
      fails++; $display("FAIL rst_stale: valid=%b instr=%h state=%0d expected 0 not-deadbeef 0", instr_valid, instr, fsm_state);
    end
    fetch_zero_wait(64'h1000, 32'h0070_0413, "rst_refetch");
  endtask

  task automatic test_misalign();
    retire(64'h1002);
`ifdef PC_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      bus.imem_gnt = 1'b1;
      #1;
      tests++;
      if (misalign !== 1'b1 || bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || pc_out !== 64'h1002) begin
        fails++;
        $display("FAIL misalign_trap: mis=%b req=%b valid=%b pc=%h expected 1 0 0 1002", misalign, bus.imem_req, instr_valid, pc_out);
      end
      @(negedge clk);
    end
    bus.imem_gnt = 1'b0;
`else
    fetch_zero_wait(64'h1002, 32'h0080_0493, "misalign_pass");
`endif
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_sequential();
    test_branch();
    test_gnt_stall();
    test_timeout();
    test_wrap();
    test_reset_in_wait();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
